// File: rtl/dealer_pkg.sv
// Shared types and helpers for the blackjack card dealer: FSM states, deck
// geometry and the rank -> blackjack face value mapping.
package dealer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DONE,
    S_SHUFFLE
  } state_e;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;

  // Ace reports 1; the game controller promotes it to 11 when that helps.
  function automatic logic [3:0] rank_to_value(logic [3:0] r);
    if (r == 4'd0) return 4'd1;
    if (r <= 4'd9) return r + 4'd1;
    return 4'd10;
  endfunction

endpackage

// File: rtl/dealer_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) supplying the
// dealer's candidate cards. A zero seed would lock up, so it is replaced.
module dealer_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  localparam logic [15:0] INIT = (SEED == 16'h0) ? 16'hACE1 : SEED;

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= INIT;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/card_dealer.sv
// 52-card shoe without repeats: an LFSR proposes a card, a used-card mask
// rejects dealt ones and a linear scan finds the next free slot.
module card_dealer
  import dealer_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          RESHUFFLE_AT = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       request,
  input  logic       shuffle,
  output logic       ready,
  output logic [3:0] value,
  output logic [5:0] card_idx,
  output logic [5:0] cards_left,
  output logic       reshuffled
);

  state_e                 state_q, state_d;
  logic [DECK_SIZE-1:0]   used_q, used_d;
  logic [5:0]             cards_left_q, cards_left_d;
  logic [5:0]             idx_q, idx_d;
  logic [5:0]             card_idx_q, card_idx_d;
  logic [3:0]             value_q, value_d;
  logic                   ready_q, ready_d;
  logic                   reshuffled_q, reshuffled_d;
  logic                   pend_q, pend_d;
  logic                   request_q;

  logic [15:0] lfsr;
  logic [5:0]  cand, found_idx, rank;
  logic        req_edge;
  logic        unused_lfsr_hi;

  dealer_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  function automatic logic [5:0] nxt_idx(logic [5:0] i);
    return (i == 6'(DECK_SIZE - 1)) ? 6'd0 : i + 6'd1;
  endfunction

  assign unused_lfsr_hi = ^lfsr[15:6];
  assign req_edge  = request & ~request_q;
  assign cand      = (lfsr[5:0] >= 6'(DECK_SIZE)) ? lfsr[5:0] - 6'(DECK_SIZE) : lfsr[5:0];
  // The dealt card is chosen on the cycle that enters DONE, so the outputs
  // are already valid while ready is high.
  assign found_idx = (state_q == S_LOAD) ? cand : idx_q;
  assign rank      = found_idx % 6'(RANKS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (shuffle)                 state_d = S_SHUFFLE;
                 else if (req_edge || pend_q) state_d = S_LOAD;
      S_LOAD:    state_d = used_q[cand]  ? S_SCAN : S_DONE;
      S_SCAN:    state_d = used_q[idx_q] ? S_SCAN : S_DONE;
      // Threshold >= 1 guarantees the next scan always finds a free card.
      S_DONE:    state_d = ((cards_left_q - 6'd1) < 6'(RESHUFFLE_AT)) ? S_SHUFFLE : S_IDLE;
      S_SHUFFLE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    used_d       = used_q;
    cards_left_d = cards_left_q;
    idx_d        = idx_q;
    card_idx_d   = card_idx_q;
    value_d      = value_q;
    ready_d      = 1'b0;
    reshuffled_d = (state_d == S_SHUFFLE);
    pend_d       = pend_q | req_edge;
    if (state_q == S_IDLE && state_d == S_LOAD) pend_d = 1'b0;

    case (state_q)
      S_LOAD:    idx_d = used_q[cand] ? nxt_idx(cand) : cand;
      S_SCAN:    if (used_q[idx_q]) idx_d = nxt_idx(idx_q);
      S_DONE: begin
        used_d[idx_q] = 1'b1;
        cards_left_d  = cards_left_q - 6'd1;
      end
      S_SHUFFLE: begin
        used_d       = '0;
        cards_left_d = 6'(DECK_SIZE);
      end
      default: ;
    endcase

    if (state_d == S_DONE) begin
      ready_d    = 1'b1;
      card_idx_d = found_idx;
      value_d    = rank_to_value(rank[3:0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      used_q       <= '0;
      cards_left_q <= 6'(DECK_SIZE);
      idx_q        <= '0;
      card_idx_q   <= '0;
      value_q      <= '0;
      ready_q      <= 1'b0;
      reshuffled_q <= 1'b0;
      pend_q       <= 1'b0;
      request_q    <= 1'b0;
    end else begin
      used_q       <= used_d;
      cards_left_q <= cards_left_d;
      idx_q        <= idx_d;
      card_idx_q   <= card_idx_d;
      value_q      <= value_d;
      ready_q      <= ready_d;
      reshuffled_q <= reshuffled_d;
      pend_q       <= pend_d;
      request_q    <= request;
    end
  end

  assign ready      = ready_q;
  assign value      = value_q;
  assign card_idx   = card_idx_q;
  assign cards_left = cards_left_q;
  assign reshuffled = reshuffled_q;

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Card source for the blackjack game; sits directly upstream of the game controller and serves its request/ready/value card interface.
- Models a 52-card shoe with no repeats: an LFSR picks a candidate card and a used-card mask rejects cards already dealt.
- Returns the blackjack face value of each card (ace = 1; the controller promotes aces to 11).
- Reshuffles automatically when the shoe runs low, or on command.

Parameters:
- LFSR_SEED, 16'hACE1, reset value of the LFSR; a value of 0 is replaced by 16'hACE1.
- RESHUFFLE_AT, 12, reshuffle after a draw that leaves cards_left < RESHUFFLE_AT; legal range 1..51.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- request  input  1  draw request from the controller; level signal, acted on at its rising edge
- shuffle  input  1  explicit reshuffle command, level
- ready  output  1  one-cycle pulse: value/card_idx hold a newly dealt card
- value  output  4  face value 1..10 of the last dealt card
- card_idx  output  6  index 0..51 of the last dealt card (suit*13 + rank)
- cards_left  output  6  undealt cards remaining, 0..52
- reshuffled  output  1  one-cycle pulse when the deck mask is cleared

Behaviour:
- Reset values while rst=0, applied immediately and asynchronously:
  - ready=0, value=0, card_idx=0, reshuffled=0
  - cards_left=52, used mask all 0, request_q=0, pend=0
  - LFSR=LFSR_SEED, state=IDLE
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Free-runs every cycle, in every state.
  - Never reaches 0.
- Request detection:
  - edge = request & ~request_q, where request_q is request registered every cycle.
  - An edge sets pend; pend clears when the state leaves IDLE for LOAD.
  - A request held high produces exactly one draw.
- State machine (IDLE, LOAD, SCAN, DONE, SHUFFLE):
  - IDLE: if shuffle=1 -> SHUFFLE; shuffle has priority, and a simultaneous edge is kept in pend. Else if edge or pend -> LOAD. Else stay.
  - LOAD: cand = lfsr[5:0], minus 52 if >= 52. If used[cand]=0 -> DONE; else idx = cand+1 (51 wraps to 0) -> SCAN.
  - SCAN: check one index per cycle. If unused -> DONE; else idx+1 with wrap. Terminates because the reshuffle threshold guarantees at least 1 unused card.
  - DONE:
    - Registers card_idx=idx and value=rank_to_value(idx mod 13) this cycle.
    - Sets used[idx] and decrements cards_left.
    - ready=1 for exactly this cycle.
    - Next state: SHUFFLE if the decremented cards_left < RESHUFFLE_AT, else IDLE.
  - SHUFFLE: clears the mask, sets cards_left=52, pulses reshuffled for 1 cycle -> IDLE.
- Value mapping by rank r = idx mod 13:
  - r=0 -> 1 (ace)
  - r=1..9 -> 2..10
  - r=10..12 (J, Q, K) -> 10
- Timing and hold:
  - Latency from request edge (edge cycle T) to ready: 2 cycles minimum (DONE at T+2), 53 maximum.
  - value and card_idx stay stable from ready until the next DONE. This covers the controller's 2-cycle ready-delayed sampling.
- shuffle asserted outside IDLE is ignored, with no queueing.
- Request edges outside IDLE set pend and are served on return to IDLE.

Decomposition:
- dealer_pkg holds:
  - the state enum
  - DECK_SIZE=52 and RANKS=13
  - the function rank_to_value(logic [3:0] r) returning logic [3:0]
- Sub-module dealer_lfsr (parameter SEED; ports clk, rst, q[15:0]) is the one natural split.
- Mask, scan and the FSM stay in card_dealer.

Test Plan:
- Reset: hold rst=0 with request toggling -> ready=0, value=0, cards_left=52, reshuffled=0. Release rst -> first edge gives ready 2..53 cycles later, value in 1..10.
- Held request: request high for 10 cycles -> exactly one ready pulse and cards_left=51. Drop and re-raise -> second ready, cards_left=50.
- Uniqueness and reshuffle (RESHUFFLE_AT=12):
  - 41 sequential draws -> all card_idx distinct; cards_left runs 51..11.
  - After draw 41, reshuffled pulses 1 cycle after ready, then cards_left=52.
  - Draw 42 -> cards_left=51.
- Mapping: check every DONE with a scoreboard. Forced idx 0 -> 1; 9 -> 10; 10 -> 10; 13 -> 1; 22 -> 10; 51 -> 10.
- Collision and wrap: preload the mask so only card 0 is free, with cand=51 -> SCAN wraps 51->0; ready carries card_idx=0, value=1.
- Simultaneous and mid-op events:
  - shuffle and request edge in the same IDLE cycle -> reshuffled pulse, then ready 2+ cycles later with cards_left=51.
  - rst=0 during SCAN -> outputs reset immediately and no ready follows.
